// File: rtl/uart_port.sv
// CPU-side 8N1 UART with 1-byte TX/RX holding registers and active-low ready flags.
// Build option: define UART_LOOPBACK_EN to feed the receiver from the internal tx line.
`timescale 1ns/1ps
module uart_port #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       _mr,
  input  logic       _wr,
  input  logic       _rd,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tx,
  input  logic       rx,
  output logic       _do_ready,
  output logic       _di_ready,
  output logic       overrun,
  output logic       frame_err
);

  localparam logic [15:0] DIV_FULL = 16'(CLK_DIV - 1);
  localparam logic [15:0] DIV_HALF = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } st_t;

  st_t         tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  thr_q, thr_d;
  logic        thr_full_q, thr_full_d;
  logic        tx_q, tx_d;
  logic        tx_load, tx_tick, wr_acc;

  st_t         rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rhr_q, rhr_d;
  logic        rhr_full_q, rhr_full_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic        s1_q, s2_q, prev_q;
  logic        rx_src, rx_tick, rx_fall;
  logic        deliver, bad_stop;

  assign tx_tick = (tx_cnt_q == 16'd0);
  assign rx_tick = (rx_cnt_q == 16'd0);
  assign wr_acc  = ~_wr & ~thr_full_q;
  assign rx_fall = prev_q & ~s2_q;

`ifdef UART_LOOPBACK_EN
  logic loop_unused;
  assign loop_unused = rx;
  assign rx_src      = tx_q;
`else
  assign rx_src = rx;
`endif

  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      tx_st_q    <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      thr_q      <= '0;
      thr_full_q <= 1'b0;
      tx_q       <= 1'b1;
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rhr_q      <= '0;
      rhr_full_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      prev_q     <= 1'b1;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      tx_q       <= tx_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rhr_q      <= rhr_d;
      rhr_full_q <= rhr_full_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      s1_q       <= rx_src;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
    end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_load  = 1'b0;
    unique case (tx_st_q)
      S_IDLE: tx_load = thr_full_q;
      S_START: begin
        if (tx_tick) begin
          tx_st_d  = S_DATA;
          tx_bit_d = '0;
          tx_cnt_d = DIV_FULL;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_tick) begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          tx_cnt_d = DIV_FULL;
          if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_tick) begin
          if (thr_full_q) tx_load = 1'b1;
          else            tx_st_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
    // back-to-back frames reuse this path straight out of STOP
    if (tx_load) begin
      tx_sh_d  = thr_q;
      tx_st_d  = S_START;
      tx_cnt_d = DIV_FULL;
    end
    thr_d      = wr_acc ? data_in : thr_q;
    thr_full_d = (thr_full_q & ~tx_load) | wr_acc;
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (tx_st_q)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_sh_q[0];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    deliver  = 1'b0;
    bad_stop = 1'b0;
    unique case (rx_st_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_st_d  = S_START;
          rx_cnt_d = DIV_HALF;
        end
      end
      S_START: begin
        if (rx_tick) begin
          rx_st_d  = s2_q ? S_IDLE : S_DATA;
          rx_bit_d = '0;
          rx_cnt_d = DIV_FULL;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_sh_d  = {s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          rx_cnt_d = DIV_FULL;
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_tick) begin
          rx_st_d  = S_IDLE;
          deliver  = s2_q;
          bad_stop = ~s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  // a read on the delivery edge frees the register before the new byte lands
  always_comb begin
    rhr_d      = rhr_q;
    rhr_full_d = rhr_full_q & _rd;
    ovr_d      = ovr_q & _rd;
    ferr_d     = (ferr_q & _rd) | bad_stop;
    if (deliver) begin
      if (rhr_full_d) begin
        ovr_d = 1'b1;
      end else begin
        rhr_d      = rx_sh_q;
        rhr_full_d = 1'b1;
      end
    end
  end

  assign data_out  = _rd ? 8'bz : rhr_q;
  assign tx        = tx_q;
  assign _do_ready = thr_full_q;
  assign _di_ready = ~rhr_full_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port at CLK_DIV=4: TX framing, double buffering, RX, errors, reset.
// Define UART_LOOPBACK_EN to run the internal loopback echo instead of the rx-pin tests.
`timescale 1ns/1ps
module tb_uart_port;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       mr_n, wr_n, rd_n, rx;
  logic [7:0] din;
  wire  [7:0] dout;
  logic       tx, do_rdy, di_rdy, ovr, ferr;

  uart_port #(.CLK_DIV(DIV)) dut (
    .clk       (clk),
    ._mr       (mr_n),
    ._wr       (wr_n),
    ._rd       (rd_n),
    .data_in   (din),
    .data_out  (dout),
    .tx        (tx),
    .rx        (rx),
    ._do_ready (do_rdy),
    ._di_ready (di_rdy),
    .overrun   (ovr),
    .frame_err (ferr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;
  } tx_vec_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_di_rdy;
    logic       exp_ferr;
  } rx_vec_t;

  tx_vec_t tv [5];
  rx_vec_t rv [4];
  logic    rec [0:119];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    @(negedge clk);
    din  = b;
    wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
  endtask

  // caller sits on a negedge; returns on the negedge before the stop mid-sample edge
  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic rd_byte(input string name, input logic [7:0] exp);
    rd_n = 1'b0;
    #1;
    check(name, dout, exp);
    @(negedge clk);
    rd_n = 1'b1;
    #1;
    check({name, "_flags"}, {di_rdy, ovr, ferr}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int   k;
    logic ok;
    logic [9:0]  got;
    logic [19:0] pat;
    string s;

    tv[0] = '{8'h48, 10'b1010010000};
    tv[1] = '{8'hA5, 10'b1101001010};
    tv[2] = '{8'h00, 10'b1000000000};
    tv[3] = '{8'hFF, 10'b1111111110};
    tv[4] = '{8'h81, 10'b1100000010};
    rv[0] = '{8'h21, 1'b1, 1'b0, 1'b0};
    rv[1] = '{8'hC3, 1'b1, 1'b0, 1'b0};
    rv[2] = '{8'h5A, 1'b0, 1'b1, 1'b1};
    rv[3] = '{8'h80, 1'b1, 1'b0, 1'b0};

    mr_n = 1'b0; wr_n = 1'b1; rd_n = 1'b1; rx = 1'b1; din = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {tx, do_rdy, di_rdy, ovr, ferr}, 5'b10100);
    total++;
    if (dout === 8'bz) passed++;
    else $display("FAIL dout_hiz got=%0h exp=zz", dout);
    mr_n = 1'b1;
    @(negedge clk);

`ifdef UART_LOOPBACK_EN
    s = "Hello!\n";
    for (int i = 0; i < s.len(); i++) begin
      k = 0;
      while (do_rdy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
      check("lb_do_wait", k < 200, 1);
      wr_byte(s[i]);
      k = 0;
      while (di_rdy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
      check("lb_di_wait", k < 200, 1);
      rd_byte("lb_echo", s[i]);
    end
`endif

    foreach (tv[v]) begin
      wr_byte(tv[v].d);
      check("tx_do_set", do_rdy, 1);
      k = 0;
      while (tx === 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
        if (k == 1) check("tx_do_clr", do_rdy, 0);
      end
      check("tx_latency", k, 2);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        got[i] = tx;
        repeat (DIV) @(negedge clk);
      end
      check("tx_frame", got, tv[v].frame);
      repeat (4) @(negedge clk);
    end

    // double buffering: second byte queued mid-frame, third dropped
    pat = 20'b1011011000_1011001010;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      rec[c] = tx;
      if (c == 20) check("b2b_full", do_rdy, 1);
      if (c == 0)  begin din = 8'h65; wr_n = 1'b0; end
      if (c == 12) begin din = 8'h6C; wr_n = 1'b0; end
      if (c == 20) begin din = 8'h99; wr_n = 1'b0; end
      if (c == 1 || c == 13 || c == 21) wr_n = 1'b1;
    end
    ok = rec[0] & rec[1] & rec[2];
    for (int c = 3; c < 83; c++) if (rec[c] !== pat[(c - 3) / 4]) ok = 1'b0;
    check("b2b_frames", ok, 1);
    ok = 1'b1;
    for (int c = 83; c < 120; c++) if (rec[c] !== 1'b1) ok = 1'b0;
    check("b2b_drop", ok, 1);

`ifndef UART_LOOPBACK_EN
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch", {di_rdy, ovr, ferr}, 3'b100);

    foreach (rv[v]) begin
      send(rv[v].d, rv[v].stop);
      repeat (2) @(negedge clk);
      check("rx_flags", {di_rdy, ferr}, {rv[v].exp_di_rdy, rv[v].exp_ferr});
      rd_n = 1'b0;
      #1;
      if (!rv[v].exp_di_rdy) check("rx_data", dout, rv[v].d);
      @(negedge clk);
      rd_n = 1'b1;
      #1;
      check("rx_rd_clr", {di_rdy, ovr, ferr}, 3'b100);
      repeat (4) @(negedge clk);
    end

    send(8'hAA, 1'b1);
    repeat (4) @(negedge clk);
    send(8'h55, 1'b1);
    repeat (2) @(negedge clk);
    check("ovr_flags", {di_rdy, ovr}, 2'b01);
    rd_byte("ovr_keep", 8'hAA);
    repeat (4) @(negedge clk);

    // read lands on the same edge as the next delivery
    send(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    send(8'h22, 1'b1);
    rd_n = 1'b0;
    #1;
    check("rdlv_old", dout, 8'h11);
    @(negedge clk);
    rd_n = 1'b1;
    #1;
    check("rdlv_flags", {di_rdy, ovr}, 2'b00);
    rd_byte("rdlv_new", 8'h22);
    repeat (4) @(negedge clk);

    send(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    send(8'h77, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_rst_rx", {di_rdy, ferr}, 2'b01);
`endif

    wr_byte(8'h00);
    @(negedge clk);
    fork
      send(8'h0F, 1'b1);
      begin
        repeat (22) @(negedge clk);
        check("pre_rst_tx", tx, 0);
        #2;
        mr_n = 1'b0;
        #1;
        check("mid_rst", {tx, do_rdy, di_rdy, ovr, ferr}, 5'b10100);
      end
    join
    @(negedge clk);
    mr_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst", {tx, do_rdy, di_rdy, ovr, ferr}, 5'b10100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
